// File: rtl/full_adder_pkg.sv
// Shared constants and result type for the registered ripple-carry adder.
package full_adder_pkg;

  // Operand width; the top level exposes one scalar port per bit of this width.
  localparam int unsigned Width = 8;

  // Registered result: per-stage carries alongside the sum bits.
  typedef struct packed {
    logic [Width-1:0] carry;
    logic [Width-1:0] sum;
  } add_res_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder stage; purely combinational.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and majority-carry of the three inputs.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/full_adder.sv
// 8-bit registered ripple-carry adder exposing every stage carry-out.
module full_adder
  import full_adder_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in1_1,
  input  logic in1_2,
  input  logic in1_3,
  input  logic in1_4,
  input  logic in1_5,
  input  logic in1_6,
  input  logic in1_7,
  input  logic in1_8,
  input  logic in2_1,
  input  logic in2_2,
  input  logic in2_3,
  input  logic in2_4,
  input  logic in2_5,
  input  logic in2_6,
  input  logic in2_7,
  input  logic in2_8,
  output logic Sum1,
  output logic Sum2,
  output logic Sum3,
  output logic Sum4,
  output logic Sum5,
  output logic Sum6,
  output logic Sum7,
  output logic Sum8,
  output logic carry1,
  output logic carry2,
  output logic carry3,
  output logic carry4,
  output logic carry5,
  output logic carry6,
  output logic carry7,
  output logic carry8
);

  logic [Width-1:0] op_a;
  logic [Width-1:0] op_b;
  logic [Width-1:0] sum_w;
  logic [Width-1:0] carry_w;
  add_res_t         res_d;
  add_res_t         res_q;

  assign op_a = {in1_8, in1_7, in1_6, in1_5, in1_4, in1_3, in1_2, in1_1};
  assign op_b = {in2_8, in2_7, in2_6, in2_5, in2_4, in2_3, in2_2, in2_1};

  // Ripple chain: each stage owns its own carry wire so the chain is a set of
  // independent scalars rather than one vector feeding back into itself.
  for (genvar i = 0; i < Width; i++) begin : g_stage
    logic cin_w;
    logic s_w;
    logic cout_w;

    if (i == 0) begin : g_first
      assign cin_w = 1'b0;
    end else begin : g_next
      assign cin_w = g_stage[i-1].cout_w;
    end

    full_adder_bit u_bit (
      .a   (op_a[i]),
      .b   (op_b[i]),
      .cin (cin_w),
      .s   (s_w),
      .cout(cout_w)
    );

    assign sum_w[i]   = s_w;
    assign carry_w[i] = cout_w;
  end

  // Next-state result straight from the ripple chain; no enable.
  always_comb begin
    res_d       = '0;
    res_d.sum   = sum_w;
    res_d.carry = carry_w;
  end

  // Result register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign {Sum8, Sum7, Sum6, Sum5, Sum4, Sum3, Sum2, Sum1} = res_q.sum;
  assign {carry8, carry7, carry6, carry5, carry4, carry3, carry2, carry1} = res_q.carry;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder using an expected-result queue.
module tb_full_adder;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_v;
  logic [7:0] b_v;
  logic [7:0] sum_v;
  logic [7:0] carry_v;

  logic [15:0] exp_q[$];
  logic [15:0] last_exp;
  int          total;
  int          bad;

  full_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in1_1 (a_v[0]),
    .in1_2 (a_v[1]),
    .in1_3 (a_v[2]),
    .in1_4 (a_v[3]),
    .in1_5 (a_v[4]),
    .in1_6 (a_v[5]),
    .in1_7 (a_v[6]),
    .in1_8 (a_v[7]),
    .in2_1 (b_v[0]),
    .in2_2 (b_v[1]),
    .in2_3 (b_v[2]),
    .in2_4 (b_v[3]),
    .in2_5 (b_v[4]),
    .in2_6 (b_v[5]),
    .in2_7 (b_v[6]),
    .in2_8 (b_v[7]),
    .Sum1  (sum_v[0]),
    .Sum2  (sum_v[1]),
    .Sum3  (sum_v[2]),
    .Sum4  (sum_v[3]),
    .Sum5  (sum_v[4]),
    .Sum6  (sum_v[5]),
    .Sum7  (sum_v[6]),
    .Sum8  (sum_v[7]),
    .carry1(carry_v[0]),
    .carry2(carry_v[1]),
    .carry3(carry_v[2]),
    .carry4(carry_v[3]),
    .carry5(carry_v[4]),
    .carry6(carry_v[5]),
    .carry7(carry_v[6]),
    .carry8(carry_v[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: carry out of stage i is bit i of the sum of the low i bits.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] m;
    logic [8:0] part;
    logic [8:0] full;
    logic [7:0] c;
    for (int i = 0; i < 8; i++) begin
      m    = (9'd1 << (i + 1)) - 9'd1;
      part = ({1'b0, a} & m) + ({1'b0, b} & m);
      c[i] = part[i+1];
    end
    full = {1'b0, a} + {1'b0, b};
    return {c, full[7:0]};
  endfunction

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: carry/sum got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive operands away from the edge, queue the expectation, check after the edge.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    @(negedge clk);
    a_v = a;
    b_v = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty got=%h expected=entry", tag, {carry_v, sum_v});
    end else begin
      last_exp = exp_q.pop_front();
      check_val(tag, {carry_v, sum_v}, last_exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a_v   = 8'hAA;
    b_v   = 8'h55;
    #2;
    check_val("reset_async", {carry_v, sum_v}, 16'h0000);

    // Clocks while held in reset must not load anything.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      a_v = 8'(i * 37 + 200);
      b_v = 8'(i * 91 + 77);
      check_val("reset_hold", {carry_v, sum_v}, 16'h0000);
    end

    @(negedge clk);
    rst_n = 1'b1;

    run_op("first_load", 8'd0,   8'd0,   16'h0000);
    run_op("one_plus_one", 8'd1, 8'd1,   16'h0102);
    run_op("68_plus_5",  8'd68,  8'd5,   16'h0449);
    run_op("255_plus_1", 8'd255, 8'd1,   16'hFF00);
    run_op("255_plus_255", 8'd255, 8'd255, 16'hFFFE);
    run_op("alt_bits",   8'hAA,  8'h55,  16'h00FF);
    run_op("msb_only",   8'h80,  8'h80,  16'h8000);

    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op("random", ra, rb, model(ra, rb));
    end

    // Mid-cycle operand change stays invisible until the next edge.
    run_op("pre_change", 8'd100, 8'd200, model(8'd100, 8'd200));
    a_v = 8'd3;
    b_v = 8'd4;
    #3;
    check_val("mid_cycle_hold", {carry_v, sum_v}, last_exp);

    // Reset dropped between edges clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_clear", {carry_v, sum_v}, 16'h0000);
    @(posedge clk);
    #1;
    check_val("clear_hold", {carry_v, sum_v}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("after_reset", 8'd3, 8'd4, 16'h0007);
    run_op("final_ripple", 8'd127, 8'd1, 16'h7F80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
